// File: rtl/msp430_trace_buffer_if.sv
// Trace buffer bus: decode sampling inputs, capture control, trigger setup and
// the handshaked readout port. Clock and reset stay outside the interface.
interface msp430_trace_buffer_if #(
  parameter int DEPTH = 16,
  parameter int PC_W  = 16,
  parameter int CYC_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 1 + 16 + PC_W + CYC_W;

  logic            decode;
  logic [15:0]     ir;
  logic [PC_W-1:0] pc;
  logic            irq_detect;
  logic            arm;
  logic            stop;
  logic            mode_wrap;
  logic            trig_en;
  logic [PC_W-1:0] trig_pc;
  logic [CW-1:0]   post_cnt;
  logic            rd_req;
  logic            rd_valid;
  logic [EW-1:0]   rd_data;
  logic            rd_empty;
  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic            wrapped;
  logic            triggered;
  logic [31:0]     inst_number;

  modport master (
    output decode, ir, pc, irq_detect, arm, stop, mode_wrap,
           trig_en, trig_pc, post_cnt, rd_req,
    input  rd_valid, rd_data, rd_empty, state, count, wrapped,
           triggered, inst_number
  );

  modport slave (
    input  decode, ir, pc, irq_detect, arm, stop, mode_wrap,
           trig_en, trig_pc, post_cnt, rd_req,
    output rd_valid, rd_data, rd_empty, state, count, wrapped,
           triggered, inst_number
  );
endinterface

// File: rtl/msp430_trace_buffer.sv
// MSP430 instruction-trace recorder: circular buffer of {irq, opcode, pc, cyc}
// entries with wrap / stop-on-full modes and a one-cycle-latency readout port.
// Optional PC-match trigger with post-trigger capture: define TRACE_TRIGGER_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, nothing captured, readout allowed
// RUN   | capturing every decode
// POST  | trigger seen, capturing the remaining post-trigger entries
// DONE  | capture finished, readout allowed
module msp430_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int PC_W  = 16,
  parameter int CYC_W = 8
) (
  input logic                 mclk,
  input logic                 puc_rst_n,
  msp430_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 1 + 16 + PC_W + CYC_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_POST = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CW-1:0]    FULL    = CW'(DEPTH);
  localparam logic [CYC_W-1:0] CYC_SAT = {{(CYC_W-1){1'b1}}, 1'b0};

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    unread_q, unread_d;
  logic [CW-1:0]    remaining_q, remaining_d;
  logic             wrapped_q, wrapped_d;
  logic             triggered_q, triggered_d;
  logic [CYC_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0]      inst_number_q, inst_number_d;
  logic             rd_valid_q, rd_valid_d;
  logic [EW-1:0]    rd_data_q, rd_data_d;

  logic [EW-1:0]    mem_q [DEPTH];
  logic             mem_we;
  logic [EW-1:0]    entry;
  logic             full;
  logic             trig_hit;
  logic [CW-1:0]    post_load;

`ifdef TRACE_TRIGGER_EN
  assign trig_hit  = bus.trig_en && (bus.pc == bus.trig_pc);
  assign post_load = bus.post_cnt;
`else
  logic trig_unused;
  assign trig_hit    = 1'b0;
  assign post_load   = '0;
  assign trig_unused = ^{bus.trig_en, bus.trig_pc, bus.post_cnt};
`endif

  assign full  = (count_q == FULL);
  // Recorded cyc is cycles since the previous decode, so back-to-back decodes log 1.
  assign entry = {bus.irq_detect, bus.ir, bus.pc, cyc_cnt_q + CYC_W'(1)};

  // Next-state logic: arm overrides everything, then capture or readout per state.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    unread_d      = unread_q;
    remaining_d   = remaining_q;
    wrapped_d     = wrapped_q;
    triggered_d   = triggered_q;
    rd_valid_d    = 1'b0;
    rd_data_d     = rd_data_q;
    mem_we        = 1'b0;
    inst_number_d = inst_number_q + 32'(bus.decode);
    if (bus.decode)               cyc_cnt_d = '0;
    else if (cyc_cnt_q == CYC_SAT) cyc_cnt_d = cyc_cnt_q;
    else                          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);

    if (bus.arm) begin
      state_d     = ST_RUN;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      unread_d    = '0;
      remaining_d = '0;
      wrapped_d   = 1'b0;
      triggered_d = 1'b0;
    end else begin
      case (state_q)
        ST_RUN, ST_POST: begin
          if (bus.decode) begin
            if (full && !bus.mode_wrap) begin
              state_d = ST_DONE;
            end else begin
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + AW'(1);
              // rd_ptr tracks the oldest entry, so it follows wr_ptr once overwriting
              if (full) begin
                rd_ptr_d  = rd_ptr_q + AW'(1);
                wrapped_d = 1'b1;
              end else begin
                count_d = count_q + CW'(1);
              end
              if (state_q == ST_POST) remaining_d = remaining_q - CW'(1);
              if (state_q == ST_RUN && trig_hit) triggered_d = 1'b1;

              if (!bus.mode_wrap && count_q == FULL - CW'(1)) begin
                state_d = ST_DONE;
              end else if (bus.stop) begin
                state_d = ST_DONE;
              end else if (state_q == ST_RUN && trig_hit) begin
                remaining_d = post_load;
                state_d     = (post_load == '0) ? ST_DONE : ST_POST;
              end else if (state_q == ST_POST && remaining_q <= CW'(1)) begin
                state_d = ST_DONE;
              end
            end
          end else if (bus.stop) begin
            state_d = ST_DONE;
          end
        end
        default: begin
          if (bus.rd_req && unread_q != '0) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + AW'(1);
            unread_d   = unread_q - CW'(1);
          end
        end
      endcase
      if (state_d == ST_DONE && state_q != ST_DONE) unread_d = count_d;
    end
  end

  // Control and status registers.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      unread_q      <= '0;
      remaining_q   <= '0;
      wrapped_q     <= 1'b0;
      triggered_q   <= 1'b0;
      cyc_cnt_q     <= '0;
      inst_number_q <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      unread_q      <= unread_d;
      remaining_q   <= remaining_d;
      wrapped_q     <= wrapped_d;
      triggered_q   <= triggered_d;
      cyc_cnt_q     <= cyc_cnt_d;
      inst_number_q <= inst_number_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Trace storage; deliberately not reset so history survives a PUC.
  always_ff @(posedge mclk) begin
    if (mem_we) mem_q[wr_ptr_q] <= entry;
  end

  assign bus.state       = state_q;
  assign bus.count       = count_q;
  assign bus.wrapped     = wrapped_q;
  assign bus.triggered   = triggered_q;
  assign bus.inst_number = inst_number_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_empty    = (unread_q == '0);
endmodule

// File: tb/tb_msp430_trace_buffer.sv
// Self-checking bench for msp430_trace_buffer: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_msp430_trace_buffer;
  localparam int DEPTH = 16;
  localparam int PC_W  = 16;
  localparam int CYC_W = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = 1 + 16 + PC_W + CYC_W;
  localparam int S_IDLE = 0, S_RUN = 1, S_POST = 2, S_DONE = 3;
  localparam int CYC_MAX = (1 << CYC_W) - 1;

  logic mclk = 1'b0;
  logic puc_rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  msp430_trace_buffer_if #(.DEPTH(DEPTH), .PC_W(PC_W), .CYC_W(CYC_W)) bus ();
  msp430_trace_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .CYC_W(CYC_W)) dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .bus(bus)
  );

  always #5 mclk = ~mclk;

  // reference model
  int            m_state;
  logic [EW-1:0] m_q[$];
  int            m_count;
  bit            m_wrapped;
  bit            m_trig;
  int            m_remaining;
  logic [31:0]   m_inst;
  bit            m_rd_valid;
  logic [EW-1:0] m_rd_data;
  int            cyc_idx;
  int            last_dec;

  task automatic model_reset();
    m_state = S_IDLE; m_q.delete(); m_count = 0; m_wrapped = 0; m_trig = 0;
    m_remaining = 0; m_inst = 0; m_rd_valid = 0; m_rd_data = '0;
    cyc_idx = 0; last_dec = 0;
  endtask

  task automatic do_reset();
    puc_rst_n = 1'b0;
    bus.decode = 0; bus.ir = '0; bus.pc = '0; bus.irq_detect = 0; bus.arm = 0;
    bus.stop = 0; bus.mode_wrap = 0; bus.trig_en = 0; bus.trig_pc = '0;
    bus.post_cnt = '0; bus.rd_req = 0;
    repeat (2) @(posedge mclk);
    #1 puc_rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: apply inputs, let the edge happen, then advance the model.
  task automatic tick(input bit dec, input logic [15:0] ir_v, input logic [PC_W-1:0] pc_v,
                      input bit irq_v, input bit arm_v, input bit stop_v, input bit rd_v);
    logic [EW-1:0] ent;
    int gap;
    bit trig_now;
    bus.decode = dec; bus.ir = ir_v; bus.pc = pc_v; bus.irq_detect = irq_v;
    bus.arm = arm_v; bus.stop = stop_v; bus.rd_req = rd_v;
    @(posedge mclk);
    #1;
    bus.decode = 0; bus.arm = 0; bus.stop = 0; bus.rd_req = 0;
    cyc_idx++;
    gap = cyc_idx - last_dec;
    if (gap > CYC_MAX) gap = CYC_MAX;
    ent = {irq_v, ir_v, pc_v, CYC_W'(gap)};
    trig_now = 1'b0;
    m_rd_valid = 0;
    if (dec) begin last_dec = cyc_idx; m_inst++; end
    if (arm_v) begin
      m_q.delete(); m_count = 0; m_wrapped = 0; m_trig = 0; m_state = S_RUN;
    end else if (m_state == S_RUN || m_state == S_POST) begin
      if (dec) begin
        m_q.push_back(ent);
        if (m_q.size() > DEPTH) begin void'(m_q.pop_front()); m_wrapped = 1; end
        m_count = m_q.size();
        if (m_state == S_POST) m_remaining--;
`ifdef TRACE_TRIGGER_EN
        if (m_state == S_RUN && bus.trig_en && pc_v == bus.trig_pc) trig_now = 1'b1;
`endif
        if (trig_now) m_trig = 1;
        if (!bus.mode_wrap && m_q.size() == DEPTH) m_state = S_DONE;
        else if (stop_v) m_state = S_DONE;
        else if (trig_now) begin
          m_remaining = int'(bus.post_cnt);
          m_state = (m_remaining == 0) ? S_DONE : S_POST;
        end else if (m_state == S_POST && m_remaining == 0) m_state = S_DONE;
      end else if (stop_v) m_state = S_DONE;
    end else if (rd_v && m_q.size() > 0) begin
      m_rd_valid = 1;
      m_rd_data = m_q.pop_front();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, '0, '0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.wrapped !== 1'b0) begin errors++; $display("FAIL reset_wrapped got=%b exp=0", bus.wrapped); end
    checks++; if (bus.triggered !== 1'b0) begin errors++; $display("FAIL reset_triggered got=%b exp=0", bus.triggered); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
    checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data); end
    checks++; if (bus.rd_empty !== 1'b1) begin errors++; $display("FAIL reset_rd_empty got=%b exp=1", bus.rd_empty); end
    checks++; if (bus.inst_number !== 32'd0) begin errors++; $display("FAIL reset_inst got=%0d exp=0", bus.inst_number); end
    tick(0, '0, '0, 0, 0, 0, 1);
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL idle_empty_read got=%b exp=0", bus.rd_valid); end
  endtask

  task automatic test_stop_on_full();
    logic [PC_W-1:0] pcv;
    bus.mode_wrap = 0;
    tick(0, '0, '0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      pcv = PC_W'(16'h1000 + 2 * i);
      tick(1, 16'($urandom), pcv, 1'($urandom), 0, 0, 0);
      if (i == 15) begin
        checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL full_done_state got=%0d exp=3", bus.state); end
      end
    end
    checks++; if (bus.count !== CW'(16)) begin errors++; $display("FAIL full_count got=%0d exp=16", bus.count); end
    checks++; if (bus.wrapped !== 1'b0) begin errors++; $display("FAIL full_wrapped got=%b exp=0", bus.wrapped); end
    for (int i = 0; i < 16; i++) begin
      tick(0, '0, '0, 0, 0, 0, 1);
      checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL full_rd_valid idx=%0d got=%b exp=1", i, bus.rd_valid); end
      checks++; if (bus.rd_data[CYC_W +: PC_W] !== PC_W'(16'h1000 + 2 * i)) begin errors++; $display("FAIL full_rd_pc idx=%0d got=%h exp=%h", i, bus.rd_data[CYC_W +: PC_W], 16'h1000 + 2 * i); end
      checks++; if (bus.rd_data !== m_rd_data) begin errors++; $display("FAIL full_rd_entry idx=%0d got=%h exp=%h", i, bus.rd_data, m_rd_data); end
    end
    checks++; if (bus.rd_empty !== 1'b1) begin errors++; $display("FAIL full_rd_empty got=%b exp=1", bus.rd_empty); end
    tick(0, '0, '0, 0, 0, 0, 1);
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL full_extra_read got=%b exp=0", bus.rd_valid); end
  endtask

  task automatic test_wrap();
    bus.mode_wrap = 1;
    tick(0, '0, '0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) tick(1, 16'($urandom), PC_W'(16'h1000 + 2 * i), 1'($urandom), 0, 0, 0);
    tick(0, '0, '0, 0, 0, 1, 0);
    checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL wrap_state got=%0d exp=3", bus.state); end
    checks++; if (bus.wrapped !== 1'b1) begin errors++; $display("FAIL wrap_wrapped got=%b exp=1", bus.wrapped); end
    checks++; if (bus.count !== CW'(16)) begin errors++; $display("FAIL wrap_count got=%0d exp=16", bus.count); end
    for (int i = 0; i < 16; i++) begin
      tick(0, '0, '0, 0, 0, 0, 1);
      checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== m_rd_data) begin errors++; $display("FAIL wrap_rd idx=%0d got=%b/%h exp=1/%h", i, bus.rd_valid, bus.rd_data, m_rd_data); end
      if (i == 0) begin
        checks++; if (bus.rd_data[CYC_W +: PC_W] !== 16'h1008) begin errors++; $display("FAIL wrap_first_pc got=%h exp=1008", bus.rd_data[CYC_W +: PC_W]); end
      end
      if (i == 15) begin
        checks++; if (bus.rd_data[CYC_W +: PC_W] !== 16'h1026) begin errors++; $display("FAIL wrap_last_pc got=%h exp=1026", bus.rd_data[CYC_W +: PC_W]); end
      end
    end
    bus.mode_wrap = 0;
  endtask

  task automatic test_cyc_spacing();
    logic [CYC_W-1:0] exp_cyc [4];
    exp_cyc[0] = '0; exp_cyc[1] = CYC_W'(1); exp_cyc[2] = CYC_W'(3); exp_cyc[3] = CYC_W'(255);
    tick(0, '0, '0, 0, 1, 0, 0);
    tick(1, 16'h4031, 16'h2000, 0, 0, 0, 0);
    tick(1, 16'h4032, 16'h2002, 0, 0, 0, 0);
    idle(2);
    tick(1, 16'h4033, 16'h2004, 1, 0, 0, 0);
    idle(299);
    tick(1, 16'h4034, 16'h2006, 0, 0, 0, 0);
    tick(0, '0, '0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, '0, '0, 0, 0, 0, 1);
      checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== m_rd_data) begin errors++; $display("FAIL cyc_rd idx=%0d got=%b/%h exp=1/%h", i, bus.rd_valid, bus.rd_data, m_rd_data); end
      if (i > 0) begin
        checks++; if (bus.rd_data[CYC_W-1:0] !== exp_cyc[i]) begin errors++; $display("FAIL cyc_field idx=%0d got=%0d exp=%0d", i, bus.rd_data[CYC_W-1:0], exp_cyc[i]); end
      end
    end
  endtask

  task automatic test_trigger();
    int exp_count;
    logic [PC_W-1:0] exp_last;
    logic exp_trig;
`ifdef TRACE_TRIGGER_EN
    exp_count = 12; exp_last = 16'h1016; exp_trig = 1'b1;
`else
    exp_count = 16; exp_last = 16'h101E; exp_trig = 1'b0;
`endif
    bus.mode_wrap = 0; bus.trig_en = 1; bus.trig_pc = 16'h1010; bus.post_cnt = CW'(3);
    tick(0, '0, '0, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) tick(1, 16'($urandom), PC_W'(16'h1000 + 2 * i), 0, 0, 0, 0);
    checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL trig_state got=%0d exp=3", bus.state); end
    checks++; if (bus.triggered !== exp_trig) begin errors++; $display("FAIL trig_flag got=%b exp=%b", bus.triggered, exp_trig); end
    checks++; if (bus.count !== CW'(exp_count)) begin errors++; $display("FAIL trig_count got=%0d exp=%0d", bus.count, exp_count); end
    for (int i = 0; i < exp_count; i++) begin
      tick(0, '0, '0, 0, 0, 0, 1);
      checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== m_rd_data) begin errors++; $display("FAIL trig_rd idx=%0d got=%b/%h exp=1/%h", i, bus.rd_valid, bus.rd_data, m_rd_data); end
    end
    checks++; if (bus.rd_data[CYC_W +: PC_W] !== exp_last) begin errors++; $display("FAIL trig_last_pc got=%h exp=%h", bus.rd_data[CYC_W +: PC_W], exp_last); end
    bus.trig_en = 0;
  endtask

  task automatic test_simultaneous();
    tick(0, '0, '0, 0, 1, 1, 0);
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL armstop_state got=%0d exp=1", bus.state); end
    tick(1, 16'h1234, 16'h3000, 0, 0, 0, 0);
    tick(0, '0, '0, 0, 0, 0, 1);
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL run_read got=%b exp=0", bus.rd_valid); end
    tick(1, 16'h1235, 16'h3002, 0, 1, 0, 0);
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL armdec_count got=%0d exp=0", bus.count); end
    tick(1, 16'h1236, 16'h3004, 0, 0, 1, 0);
    checks++; if (bus.count !== CW'(1) || bus.state !== 2'd3) begin errors++; $display("FAIL stopdec got=%0d/%0d exp=1/3", bus.count, bus.state); end
    checks++; if (bus.rd_empty !== 1'b0) begin errors++; $display("FAIL stopdec_empty got=%b exp=0", bus.rd_empty); end
    tick(0, '0, '0, 0, 1, 0, 1);
    checks++; if (bus.rd_valid !== 1'b0 || bus.state !== 2'd1) begin errors++; $display("FAIL armread got=%b/%0d exp=0/1", bus.rd_valid, bus.state); end
    checks++; if (bus.inst_number !== m_inst) begin errors++; $display("FAIL sim_inst got=%0d exp=%0d", bus.inst_number, m_inst); end
  endtask

  task automatic test_reset_mid_run();
    tick(0, '0, '0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) tick(1, 16'($urandom), PC_W'($urandom), 0, 0, 0, 0);
    #2 puc_rst_n = 1'b0;
    #1;
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL rst_mid_state got=%0d exp=0", bus.state); end
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", bus.count); end
    checks++; if (bus.rd_empty !== 1'b1) begin errors++; $display("FAIL rst_mid_empty got=%b exp=1", bus.rd_empty); end
    checks++; if (bus.inst_number !== 32'd0) begin errors++; $display("FAIL rst_mid_inst got=%0d exp=0", bus.inst_number); end
    do_reset();
  endtask

  task automatic test_random();
    int n, gap, budget;
    for (int it = 0; it < 10; it++) begin
      bus.mode_wrap = 1'($urandom);
      bus.trig_en   = 1'($urandom);
      bus.trig_pc   = PC_W'(16'h1000 + 2 * $urandom_range(0, 15));
      bus.post_cnt  = CW'($urandom_range(0, 6));
      tick(0, '0, '0, 0, 1, 0, 0);
      n = $urandom_range(0, 40);
      for (int k = 0; k < n; k++) begin
        gap = ($urandom_range(0, 19) == 0) ? 260 : $urandom_range(0, 3);
        idle(gap);
        tick(1, 16'($urandom), PC_W'(16'h1000 + 2 * $urandom_range(0, 15)), 1'($urandom),
             0, ($urandom_range(0, 29) == 0), 0);
      end
      if (m_state != S_DONE) tick(0, '0, '0, 0, 0, 1, 0);
      checks++; if (bus.state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state it=%0d got=%0d exp=%0d", it, bus.state, m_state); end
      checks++; if (bus.count !== CW'(m_count) || bus.wrapped !== m_wrapped || bus.triggered !== m_trig) begin errors++; $display("FAIL rnd_status it=%0d got=%0d/%b/%b exp=%0d/%b/%b", it, bus.count, bus.wrapped, bus.triggered, m_count, m_wrapped, m_trig); end
      checks++; if (bus.inst_number !== m_inst) begin errors++; $display("FAIL rnd_inst it=%0d got=%0d exp=%0d", it, bus.inst_number, m_inst); end
      budget = 200;
      while (m_q.size() > 0 && budget > 0) begin
        tick(0, '0, '0, 0, 0, 0, 1'($urandom));
        budget--;
        checks++; if (bus.rd_valid !== m_rd_valid) begin errors++; $display("FAIL rnd_rd_valid it=%0d got=%b exp=%b", it, bus.rd_valid, m_rd_valid); end
        if (m_rd_valid) begin
          checks++; if (bus.rd_data !== m_rd_data) begin errors++; $display("FAIL rnd_rd_data it=%0d got=%h exp=%h", it, bus.rd_data, m_rd_data); end
        end
      end
      checks++; if (budget == 0) begin errors++; $display("FAIL rnd_read_timeout it=%0d got=%0d left exp=0", it, m_q.size()); end
      checks++; if (bus.rd_empty !== 1'b1) begin errors++; $display("FAIL rnd_rd_empty it=%0d got=%b exp=1", it, bus.rd_empty); end
    end
    bus.trig_en = 0;
  endtask

  initial begin
    test_reset();
    test_stop_on_full();
    test_wrap();
    test_cyc_spacing();
    test_trigger();
    test_simultaneous();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/msp430_trace_buffer.md
# msp430_trace_buffer

Parametrised instruction-trace recorder for the MSP430 core: captures one entry per decoded instruction (opcode, PC, IRQ flag, cycle count) into a circular buffer of configurable depth. Supports wrap or stop-on-full modes, an optional PC-match trigger with post-trigger capture, and a handshaked readout port. Sits beside the core in the testbench/debug domain, sampling the same core-internal decode signals the debug monitor uses. Successor to the ASCII debug monitor, adding storage and history.

## Interface
- DEPTH, 16, trace entries; power of two, ≥2
- PC_W, 16, program-counter width
- CYC_W, 8, per-entry cycle-count width (saturating)
- Entry width EW = 1 + 16 + PC_W + CYC_W, packed {irq, opcode, pc, cyc} MSB→LSB
- One clock; reset is asynchronous and active-low.
- mclk  in  1  main system clock
- puc_rst_n  in  1  asynchronous active-low reset
- decode  in  1  core decode strobe, one cycle per instruction
- ir  in  16  instruction register, valid with decode
- pc  in  PC_W  instruction PC, valid with decode
- irq_detect  in  1  decode is an IRQ entry
- arm  in  1  pulse: clear buffer, start capture
- stop  in  1  pulse: end capture
- mode_wrap  in  1  1 = overwrite oldest when full, 0 = stop when full
- trig_en  in  1  enable PC trigger (TRACE_TRIGGER_EN only)
- trig_pc  in  PC_W  trigger address (TRACE_TRIGGER_EN only)
- post_cnt  in  $clog2(DEPTH)+1  entries captured after trigger entry (TRACE_TRIGGER_EN only)
- rd_req  in  1  pulse: request next entry
- rd_valid  out  1  rd_data valid, one-cycle pulse
- rd_data  out  EW  oldest unread entry
- rd_empty  out  1  no unread entries
- state  out  2  0 IDLE, 1 RUN, 2 POST, 3 DONE
- count  out  $clog2(DEPTH)+1  valid entries held
- wrapped  out  1  oldest entries overwritten
- triggered  out  1  trigger fired
- inst_number  out  32  decodes since reset

## Operation
- cyc counter: cleared on decode, else +1 saturating at 2^CYC_W−2; entry cyc = counter+1 (cycles since previous decode; back-to-back decodes record 1).
- inst_number: +1 per decode regardless of state, wraps at 2^32.
- IDLE: no capture. arm → RUN; arm clears wr_ptr, rd_ptr, count, wrapped, triggered.
- RUN: each decode writes entry at wr_ptr, wr_ptr+1 mod DEPTH, count+1 saturating at DEPTH.
  - Full (count=DEPTH) and decode: mode_wrap=1 → overwrite oldest, set wrapped; mode_wrap=0 → the DEPTH-th write moves state to DONE same edge.
  - stop → DONE.
- POST: as RUN; each capture decrements remaining; remaining reaching 0 → DONE. stop → DONE.
- DONE: no capture; readout enabled. arm → RUN.
- Readout (DONE or IDLE only): rd_req with rd_empty=0 → next cycle rd_valid=1, rd_data=entry at rd_ptr; rd_ptr+1, unread−1. First read returns oldest (index wr_ptr if wrapped, else 0). rd_req with rd_empty=1 or in RUN/POST ignored, rd_valid stays 0.
- rd_empty = 1 when unread count is 0; unread loads with count on entry to DONE.
- Simultaneous: arm beats stop; arm+decode same cycle → decode not captured; stop+decode in RUN → entry captured, then DONE; rd_req+arm → arm wins, read dropped.
- Reset mid-operation: all control/status cleared; storage array not reset.

## Timing
- Capture: entry written on the decode edge; count/wrapped update same edge.
- Readout latency 1 cycle; rd_req may be asserted every cycle for back-to-back reads.
- State transitions registered; state output reflects new state the cycle after the causing event.
- Reset values: state 0, count 0, wrapped 0, triggered 0, rd_valid 0, rd_data 0, rd_empty 1, inst_number 0.

## Configuration
- TRACE_TRIGGER_EN defined: trig_en/trig_pc/post_cnt active; in RUN, decode with trig_en=1 and pc==trig_pc captures the entry, sets triggered, enters POST with remaining=post_cnt; post_cnt=0 → DONE directly. Stop-on-full in POST still applies.
- Undefined: trigger ports present but ignored; POST unreachable; triggered tied 0.

## Test plan
- DEPTH=16, mode_wrap=0, arm, 20 decodes with pc=0x1000+2i → DONE after 16th; 16 reads return pc 0x1000..0x101E in order, then rd_empty=1.
- mode_wrap=1, 20 decodes, stop → wrapped=1, count=16; first read pc=0x1008, last 0x1026.
- Decodes spaced 1, 3, 300 cycles (CYC_W=8) → cyc fields 1, 3, 255.
- TRACE_TRIGGER_EN, trig_pc=0x1010, post_cnt=3 → DONE after entry pc 0x1016; triggered=1, count=12.
- arm+stop same cycle → state RUN; rd_req during RUN → no rd_valid.
- puc_rst_n low mid-RUN → state 0, count 0, rd_empty 1, inst_number 0.
